serial_subtractor: RTL

//  Bit-serial W-bit subtractor with borrow, the inverse of the tutorial ripple full-adder cell.

---
 rtl/serial_arith_pkg.sv | 26 ++
 rtl/full_sub_cell.sv | 22 ++
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg
//   Shared types and helpers for the bit-serial subtractor and related ripple arithmetic.
//   Contents:
//     SERSUB_DEF_WIDTH  default operand width
//     sersub_state_t    FSM state encoding (IDLE, SHIFT, DONE)
//     full_sub()        one-bit full subtractor returning {d, bo}
package serial_arith_pkg;

    localparam int unsigned SERSUB_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sersub_state_t;

    // d = a - b - bi (mod 2), bo = borrow out of this bit.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bi);
        logic d;
        logic bo;
        d  = a ^ b ^ bi;
        bo = (~a & b) | (~(a ^ b) & bi);
        return {d, bo};
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell
//   Combinational one-bit full subtractor. Used as the single datapath cell of the serial
//   subtractor; equally usable as the stage of a ripple-borrow subtractor.
//   Ports:
//     i_a   minuend bit
//     i_b   subtrahend bit
//     i_bi  borrow in
//     o_d   difference bit
//     o_bo  borrow out
module full_sub_cell
    import serial_arith_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_bi,
    output logic o_d,
    output logic o_bo
);

    assign {o_d, o_bo} = full_sub(i_a, i_b, i_bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = (a - b - bin) mod 2^WIDTH, processed LSB first,
//   one bit per clock through a single full_sub_cell and a borrow flop.
//   Handshake: operands accepted in IDLE on in_valid; result presented in DONE with out_valid
//   and held until out_ready.
//   Optional feature macro: SERSUB_OVF_EN adds the signed-overflow output ovf.
//   Ports:
//     clk        clock, rising edge
//     reset      synchronous active-high reset
//     in_valid   operands valid          in_ready   block can accept operands
//     a, b       minuend, subtrahend     bin        borrow in
//     out_valid  result valid            out_ready  consumer accepts result
//     diff       difference              bout       borrow out (a < b + bin, unsigned)
//     ovf        signed overflow (SERSUB_OVF_EN only)
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = SERSUB_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    sersub_state_t   r_state;
    sersub_state_t   w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic            r_brw;
    logic            w_d;
    logic            w_bo;

    full_sub_cell u_cell (
        .i_a  (r_a_sr[0]),
        .i_b  (r_b_sr[0]),
        .i_bi (r_brw),
        .o_d  (w_d),
        .o_bo (w_bo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CntLast) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_brw    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr <= a;
                        r_b_sr <= b;
                        r_brw  <= bin;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    // LSB-first bits enter at the MSB; after WIDTH shifts bit 0 is in place.
                    r_res_sr <= {w_d, r_res_sr[WIDTH-1:1]};
                    r_brw    <= w_bo;
                    r_cnt    <= r_cnt + CntW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERSUB_OVF_EN
    logic r_ovf;

    // On the MSB step r_brw is the borrow into the MSB and w_bo the borrow out of it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == SHIFT && r_cnt == CntLast) begin
            r_ovf <= r_brw ^ w_bo;
        end
    end

    assign ovf = r_ovf;
`endif

    assign diff = r_res_sr;
    assign bout = r_brw;

endmodule
